// File: rtl/ffa_acq_sequencer_if.sv
// rtl/ffa_acq_sequencer_if.sv - signal bundle between ffa_acq_sequencer and its peers
// Purpose: groups the ADC, sample-buffer, FFA-engine, UART and status signals.
// Ports (master = sequencer view, slave = surrounding pipeline):
//   run           level request for continuous acquisition
//   sample_valid  ADC sample present this cycle
//   buf_wr_en     sample-buffer write strobe
//   buf_wr_addr   sample-buffer write address (ADDR_W)
//   ffa_start     one-cycle start pulse to ffa_engine
//   ffa_done      ffa_engine result valid
//   ffa_period_us detected period (PERIOD_W)
//   tx_start      one-cycle byte-send request to uart_tx
//   tx_data       byte to send, valid with tx_start
//   tx_busy       uart_tx shifting a byte
//   seq_busy      sequencer not idle
//   err_timeout   sticky FFA timeout flag
interface ffa_acq_sequencer_if #(
  parameter int ADDR_W   = 14,
  parameter int PERIOD_W = 16
);
  logic                run;
  logic                sample_valid;
  logic                buf_wr_en;
  logic [ADDR_W-1:0]   buf_wr_addr;
  logic                ffa_start;
  logic                ffa_done;
  logic [PERIOD_W-1:0] ffa_period_us;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                tx_busy;
  logic                seq_busy;
  logic                err_timeout;

  modport master (
    input  run, sample_valid, ffa_done, ffa_period_us, tx_busy,
    output buf_wr_en, buf_wr_addr, ffa_start, tx_start, tx_data, seq_busy, err_timeout
  );

  modport slave (
    output run, sample_valid, ffa_done, ffa_period_us, tx_busy,
    input  buf_wr_en, buf_wr_addr, ffa_start, tx_start, tx_data, seq_busy, err_timeout
  );
endinterface

// File: rtl/ffa_acq_sequencer.sv
// rtl/ffa_acq_sequencer.sv - frame scheduler: ADC capture, FFA run, UART period report
// Purpose: fills the FFA sample buffer from the ADC stream, starts ffa_engine, waits for
//   its result (or a timeout) and sends the detected period over uart_tx, then holds off
//   before the next frame.
// Ports:
//   clk_50mhz  system clock
//   rst        synchronous active-high reset
//   bus        ffa_acq_sequencer_if.master (see interface file for signal list)
// Configuration: define SEQ_SYNC_BYTE_EN to prefix each report with a 0xA5 sync byte and
//   to report timeout frames as 0xA5,0xFF,0xFF instead of skipping the report.
module ffa_acq_sequencer #(
  parameter int BUF_SIZE       = 16384,
  parameter int ADDR_W         = 14,
  parameter int PERIOD_W       = 16,
  parameter int FFA_TIMEOUT    = 1048576,
  parameter int HOLDOFF_CYCLES = 50000
) (
  input logic                 clk_50mhz,
  input logic                 rst,
  ffa_acq_sequencer_if.master bus
);
  // One counter serves both PROCESS (timeout) and HOLDOFF, so size it for the larger.
  localparam int CNT_MAX = (FFA_TIMEOUT > HOLDOFF_CYCLES) ? FFA_TIMEOUT : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(BUF_SIZE - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(FFA_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
`ifdef SEQ_SYNC_BYTE_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  typedef enum logic [2:0] {
    IDLE, CAPTURE, PROCESS, SEND, WAIT_ACK, WAIT_DONE, HOLDOFF
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [1:0]        byte_idx, byte_idx_d;
  logic [15:0]       result, result_d;
  logic              err_q, err_d;
  logic              ffa_start_q, ffa_start_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        cur_byte;
  logic              wr_en;

  always_comb begin
    cur_byte = 8'h00;
`ifdef SEQ_SYNC_BYTE_EN
    case (byte_idx)
      2'd0:    cur_byte = 8'hA5;
      2'd1:    cur_byte = result[15:8];
      default: cur_byte = result[7:0];
    endcase
`else
    cur_byte = (byte_idx == 2'd0) ? result[15:8] : result[7:0];
`endif
  end

  always_comb begin
    state_d     = state;
    addr_d      = addr;
    cnt_d       = cnt;
    byte_idx_d  = byte_idx;
    result_d    = result;
    err_d       = err_q;
    ffa_start_d = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    wr_en       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run) begin
          state_d = CAPTURE;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      CAPTURE: begin
        wr_en = bus.sample_valid;
        if (bus.sample_valid) begin
          // BUF_SIZE is 2**ADDR_W, so the increment wraps to 0 after the last write.
          addr_d = addr + ADDR_W'(1);
          if (addr == LAST_ADDR) begin
            state_d     = PROCESS;
            cnt_d       = '0;
            ffa_start_d = 1'b1;
          end
        end
      end
      PROCESS: begin
        cnt_d = cnt + CNT_W'(1);
        // A done seen while ffa_start is still high belongs to the previous run.
        if (bus.ffa_done && !ffa_start_q) begin
          result_d   = 16'(bus.ffa_period_us);
          byte_idx_d = '0;
          state_d    = SEND;
        end else if (cnt == TIMEOUT_LAST) begin
          err_d = 1'b1;
`ifdef SEQ_SYNC_BYTE_EN
          result_d   = 16'hFFFF;
          byte_idx_d = '0;
          state_d    = SEND;
`else
          cnt_d   = '0;
          state_d = HOLDOFF;
`endif
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (byte_idx == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = HOLDOFF;
          end else begin
            byte_idx_d = byte_idx + 2'd1;
            state_d    = SEND;
          end
        end
      end
      HOLDOFF: begin
        cnt_d = cnt + CNT_W'(1);
        // run is only consulted here, so dropping it never truncates a frame.
        if (cnt == HOLDOFF_LAST) begin
          addr_d  = '0;
          state_d = bus.run ? CAPTURE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      byte_idx    <= '0;
      result      <= '0;
      err_q       <= 1'b0;
      ffa_start_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      cnt         <= cnt_d;
      byte_idx    <= byte_idx_d;
      result      <= result_d;
      err_q       <= err_d;
      ffa_start_q <= ffa_start_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign bus.buf_wr_en   = wr_en;
  assign bus.buf_wr_addr = addr;
  assign bus.ffa_start   = ffa_start_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.seq_busy    = (state != IDLE);
  assign bus.err_timeout = err_q;
endmodule
